// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_pkg
// Purpose  : Shared arbiter state encoding, default sizing constants and a
//            helper that maps a requester index to its ownership state.
// Revision : 1.0 - initial release
// ============================================================================
package mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } state_t;

    localparam int C_HOLD_MAX = 4;
    localparam int C_CNT_W    = 3;

    function automatic state_t own_state(input logic idx);
        return idx ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_out_reg.sv
`default_nettype none
// ============================================================================
// Module   : mux_out_reg
// Purpose  : 1-bit output register with valid/ready handshake. A load may
//            coincide with a downstream transfer, so no bubble is inserted.
// Revision : 1.0 - initial release
// ============================================================================
module mux_out_reg (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic d,
    input  logic out_ready,
    output logic q,
    output logic valid,
    output logic can_take
);

    logic r_q;
    logic r_valid;

    // Load has priority; otherwise a completed transfer empties the register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_q     <= 1'b0;
            r_valid <= 1'b0;
        end else if (load) begin
            r_q     <= d;
            r_valid <= 1'b1;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign q        = r_q;
    assign valid    = r_valid;
    assign can_take = !r_valid || out_ready;

endmodule
`default_nettype wire

// File: rtl/mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_sel_arbiter
// Purpose  : Round-robin arbiter with bounded hold for two 1-bit requesters.
//            Drives the 2:1 mux select and registers the chosen bit behind a
//            valid/ready output stage.
// Revision : 1.0 - initial release
// ============================================================================
module mux_sel_arbiter
    import mux_pkg::*;
#(
    parameter int HOLD_MAX = C_HOLD_MAX,
    parameter int CNT_W    = C_CNT_W
) (
    input  logic clock,
    input  logic reset,
    input  logic req_0,
    input  logic din_0,
    input  logic req_1,
    input  logic din_1,
    input  logic out_ready,
    output logic gnt_0,
    output logic gnt_1,
    output logic sel,
    output logic mux_out,
    output logic out_valid
);

    localparam logic [CNT_W-1:0] c_hold_max = CNT_W'(HOLD_MAX);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              r_sel;
    logic              w_sel_next;
    logic              w_grant;
    logic              w_gnt_idx;
    logic              w_can_take;
    logic              w_own_idx;
    logic              w_req_own;
    logic              w_req_oth;
    logic              w_mux;

    assign w_own_idx = (r_state == ST_OWN1);
    assign w_req_own = w_own_idx ? req_1 : req_0;
    assign w_req_oth = w_own_idx ? req_0 : req_1;

    // Grant decision, next ownership state and hold counter update
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_grant      = 1'b0;
        w_gnt_idx    = 1'b0;
        if (!reset && w_can_take) begin
            case (r_state)
                ST_OWN0, ST_OWN1: begin
                    if (w_req_own && (!w_req_oth || (r_cnt < c_hold_max))) begin
                        // Owner keeps the grant; counter saturates at the hold limit
                        w_grant   = 1'b1;
                        w_gnt_idx = w_own_idx;
                        if (r_cnt < c_hold_max) begin
                            w_cnt_next = r_cnt + 1'b1;
                        end
                    end else if (w_req_oth) begin
                        w_grant      = 1'b1;
                        w_gnt_idx    = !w_own_idx;
                        w_state_next = own_state(!w_own_idx);
                        w_cnt_next   = c_cnt_one;
                    end else begin
                        w_state_next = ST_IDLE;
                        w_cnt_next   = '0;
                    end
                end
                default: begin
                    // Idle (and the unused encoding): ties go to the one not served last
                    if (req_0 || req_1) begin
                        w_grant      = 1'b1;
                        w_gnt_idx    = (req_0 && req_1) ? !r_sel : req_1;
                        w_state_next = own_state(w_gnt_idx);
                        w_cnt_next   = c_cnt_one;
                    end
                end
            endcase
        end
    end

    // Arbiter state, hold counter and select register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_sel   <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_sel   <= w_sel_next;
        end
    end

    assign w_sel_next = w_grant ? w_gnt_idx : r_sel;
    assign w_mux      = w_sel_next ? din_1 : din_0;

    mux_out_reg u_out_reg (
        .clock     (clock),
        .reset     (reset),
        .load      (w_grant),
        .d         (w_mux),
        .out_ready (out_ready),
        .q         (mux_out),
        .valid     (out_valid),
        .can_take  (w_can_take)
    );

    assign gnt_0 = w_grant && !w_gnt_idx;
    assign gnt_1 = w_grant &&  w_gnt_idx;
    assign sel   = r_sel;

endmodule
`default_nettype wire
